xpb_table_gen: RTL and testbench
================================

Name: xpb_table_gen

Overview:
- Run-time generator for the XPB reduction lookup tables used by the modular squarer.
- For a modulus N captured at start, computes base = 2^SHIFT mod N by repeated modular doubling.
- Then streams the 2^DIN_BITS table entries i*base mod N (i = 0..2^DIN_BITS-1) out on a write port into the table RAM that the reduction datapath later reads.
- Acts as the writer side of the XPB lookup: the modulus is programmable instead of hard-coded in constant tables.

Parameters:
WIDTH, 1024, modulus and entry width in bits
SHIFT, 850, bit position whose weight 2^SHIFT is tabulated
DIN_BITS, 5, lookup index width; table depth is 2^DIN_BITS

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to generate a table; sampled only when busy=0
modulus  input  WIDTH  N; captured on accepted start; must be odd and >1
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when the last entry has been written
wr_en  output  1  table write strobe
wr_addr  output  DIN_BITS  table index i
wr_data  output  WIDTH  entry value i*base mod N

Behaviour:
- Reset (async, active-high): state IDLE; busy, done, wr_en = 0; wr_addr, wr_data, internal acc/base/N registers = 0. Reset asserted mid-operation aborts immediately; no further writes occur; the partial table is discarded by the consumer.
- States: IDLE -> DOUBLE -> WRITE -> DONE -> IDLE.
- IDLE: start=1 at clock edge E0 captures modulus into n_reg, sets acc=1, shift counter=0, busy=1, goes to DOUBLE. start while busy=1 is ignored; modulus changes after E0 are ignored.
- DOUBLE: one doubling per edge, at edges E1..E_SHIFT: acc <= moddbl(acc). After E_SHIFT, acc = 2^SHIFT mod N. Base is latched into base_reg, and the state becomes WRITE.
- Modular add rule: s = a + b computed at WIDTH+1 bits. Result = s-N if s >= N, else s. Operands are always < N, so one conditional subtract suffices. Doubling is add(acc, acc). The carry bit above WIDTH must participate in the compare.
- WRITE: registered outputs. Edges E_{SHIFT+1}..E_{SHIFT+2^DIN_BITS} each present one beat: wr_en=1, wr_addr=i, wr_data=entry_i.
  - entry_0 = 0.
  - entry_i = add(entry_{i-1}, base).
  - Beats are consecutive; no gaps and no back-pressure.
  - wr_addr increments by 1 and stops at 2^DIN_BITS-1 without wrapping inside the burst.
- DONE: at edge E_{SHIFT+2^DIN_BITS+1}:
  - wr_en=0; wr_addr/wr_data hold their last values.
  - done=1 for exactly one cycle; busy=0 in that same cycle.
  - Next edge returns to IDLE.
- start sampled high in the DONE cycle is not accepted; it is accepted from IDLE onwards.
- Total latency from start edge to done: SHIFT + 2^DIN_BITS + 1 cycles (default 883).
- Back-to-back runs with different modulus values must be independent; no state carries over.
- N even or N<=1: results undefined; no hang permitted. The sequence and timing above still apply.

Test Plan:
- Reset during WRITE beat 10, then release: wr_en, busy, done = 0 within the reset cycle; new start with N=0xFFF1 produces a full clean 32-beat burst.
- WIDTH=16, SHIFT=20, DIN_BITS=5, N=0xFFF1 (65521): base=240; wr_data sequence 0, 240, 480, ..., entry31=7440; wr_addr 0..31 consecutive; done 53 edges after start; busy high for exactly that window.
- WIDTH=16, SHIFT=1, N=3: base=2; entries cycle 0, 2, 1, 0, 2, 1, ... (exercises the conditional subtract every beat); entry31=2.
- WIDTH=16, SHIFT=16, N=0xFFFF (near-max, carry into bit WIDTH): base=1; entries 0..31 equal i; and with N=0x8001, doublings cross 2^WIDTH, checked against golden model.
- Default parameters, random odd 1024-bit N with MSB set: all 32 entries match a software model of i*(2^850 mod N) mod N; done at cycle 883; start pulses and modulus changes during busy have no effect.
- Two consecutive runs (N_a then N_b, start asserted the cycle after returning to IDLE): the second table matches N_b exactly.

Source files
------------

// File: rtl/xpb_table_gen.sv
`default_nettype none
// ============================================================================
// Module      : xpb_table_gen
// Description : Run-time generator for the XPB reduction lookup table.
//               Captures modulus N on start, derives base = 2^SHIFT mod N
//               through SHIFT modular doublings, then writes the
//               2^DIN_BITS entries i*base mod N into the table RAM, one
//               entry per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module xpb_table_gen #(
    parameter int WIDTH    = 1024,
    parameter int SHIFT    = 850,   // must be >= 1
    parameter int DIN_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    modulus,
    output logic                busy,
    output logic                done,
    output logic                wr_en,
    output logic [DIN_BITS-1:0] wr_addr,
    output logic [WIDTH-1:0]    wr_data
);

    localparam int                  CW         = (SHIFT > 1) ? $clog2(SHIFT) : 1;
    localparam logic [CW-1:0]       C_LAST_DBL = CW'(SHIFT - 1);
    localparam logic [DIN_BITS-1:0] C_ADDR_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DOUBLE = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [WIDTH-1:0]      r_n;
    logic [WIDTH-1:0]      r_acc;
    logic [WIDTH-1:0]      r_base;
    logic [CW-1:0]         r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_wr_en;
    logic [DIN_BITS-1:0]   r_wr_addr;
    logic [WIDTH-1:0]      r_wr_data;

    logic [WIDTH-1:0]      w_acc_dbl;
    logic [WIDTH-1:0]      w_next_entry;
    logic                  w_last_dbl;
    logic                  w_last_beat;

    // Modular add of two operands already below n. The sum is formed one bit
    // wider so the carry out of the top bit takes part in the compare.
    function automatic logic [WIDTH-1:0] mod_add(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] n
    );
        logic [WIDTH:0] s;
        logic [WIDTH:0] d;
        s = {1'b0, a} + {1'b0, b};
        d = s - {1'b0, n};
        if (s >= {1'b0, n}) begin
            mod_add = d[WIDTH-1:0];
        end else begin
            mod_add = s[WIDTH-1:0];
        end
    endfunction

    assign w_acc_dbl    = mod_add(r_acc, r_acc, r_n);
    assign w_next_entry = mod_add(r_wr_data, r_base, r_n);
    assign w_last_dbl   = (r_cnt == C_LAST_DBL);
    assign w_last_beat  = r_wr_en && (r_wr_addr == C_ADDR_MAX);

    // State register; reset aborts any run in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: start only counts in IDLE, so a request in the DONE
    // cycle or while busy is dropped.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start)       w_next_state = S_DOUBLE;
            S_DOUBLE: if (w_last_dbl)  w_next_state = S_WRITE;
            S_WRITE:  if (w_last_beat) w_next_state = S_DONE;
            S_DONE:                    w_next_state = S_IDLE;
            default:                   w_next_state = S_IDLE;
        endcase
    end

    // Datapath and registered outputs. The first WRITE cycle is recognised by
    // wr_en still being low, which emits entry 0 without needing a flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n       <= '0;
            r_acc     <= '0;
            r_base    <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n    <= modulus;
                        r_acc  <= WIDTH'(1);
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                S_DOUBLE: begin
                    r_acc <= w_acc_dbl;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last_dbl) begin
                        r_base <= w_acc_dbl;
                    end
                end
                S_WRITE: begin
                    if (!r_wr_en) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= '0;
                        r_wr_data <= '0;
                    end else if (w_last_beat) begin
                        r_wr_en <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_wr_addr <= r_wr_addr + DIN_BITS'(1);
                        r_wr_data <= w_next_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_xpb_table_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_xpb_table_gen
// Description : Directed self-checking bench for xpb_table_gen. Three 16-bit
//               instances (SHIFT 20, 1, 16) and one default-size instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xpb_table_gen;

    logic clk;
    logic reset;

    // 16-bit instances: index 0 -> SHIFT 20, 1 -> SHIFT 1, 2 -> SHIFT 16
    logic [2:0]       a_start;
    logic [2:0][15:0] a_mod;
    logic [2:0]       a_busy;
    logic [2:0]       a_done;
    logic [2:0]       a_we;
    logic [2:0][4:0]  a_addr;
    logic [2:0][15:0] a_data;

    // default-size instance (index 3)
    logic             d_start;
    logic [1023:0]    d_mod;
    logic             d_busy;
    logic             d_done;
    logic             d_we;
    logic [4:0]       d_addr;
    logic [1023:0]    d_data;

    xpb_table_gen #(.WIDTH(16), .SHIFT(20), .DIN_BITS(5)) u_s20 (
        .clk(clk), .reset(reset), .start(a_start[0]), .modulus(a_mod[0]),
        .busy(a_busy[0]), .done(a_done[0]), .wr_en(a_we[0]),
        .wr_addr(a_addr[0]), .wr_data(a_data[0]));

    xpb_table_gen #(.WIDTH(16), .SHIFT(1), .DIN_BITS(5)) u_s1 (
        .clk(clk), .reset(reset), .start(a_start[1]), .modulus(a_mod[1]),
        .busy(a_busy[1]), .done(a_done[1]), .wr_en(a_we[1]),
        .wr_addr(a_addr[1]), .wr_data(a_data[1]));

    xpb_table_gen #(.WIDTH(16), .SHIFT(16), .DIN_BITS(5)) u_s16 (
        .clk(clk), .reset(reset), .start(a_start[2]), .modulus(a_mod[2]),
        .busy(a_busy[2]), .done(a_done[2]), .wr_en(a_we[2]),
        .wr_addr(a_addr[2]), .wr_data(a_data[2]));

    xpb_table_gen u_big (
        .clk(clk), .reset(reset), .start(d_start), .modulus(d_mod),
        .busy(d_busy), .done(d_done), .wr_en(d_we),
        .wr_addr(d_addr), .wr_data(d_data));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // sampled view of the selected instance
    logic          smp_we, smp_busy, smp_done;
    logic [4:0]    smp_addr;
    logic [1023:0] smp_data;

    // capture of one run
    logic [1023:0] cap_tbl [32];
    int            cap_beats;
    int            cap_done_e;
    bit            cap_seq_ok;
    bit            cap_busy_ok;
    logic [4:0]    cap_done_addr;
    logic [1023:0] cap_done_data;
    logic          cap_done_we;

    task automatic chk(input string nm, input logic [1023:0] got, input logic [1023:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (low 128 bits)", nm, got[127:0], exp[127:0]);
        end
    endtask

    task automatic sample(input int k);
        if (k < 3) begin
            smp_we   = a_we[k];
            smp_busy = a_busy[k];
            smp_done = a_done[k];
            smp_addr = a_addr[k];
            smp_data = {1008'd0, a_data[k]};
        end else begin
            smp_we   = d_we;
            smp_busy = d_busy;
            smp_done = d_done;
            smp_addr = d_addr;
            smp_data = d_data;
        end
    endtask

    task automatic drive(input int k, input logic st, input logic [1023:0] n);
        if (k < 3) begin
            a_start[k] = st;
            a_mod[k]   = n[15:0];
        end else begin
            d_start = st;
            d_mod   = n;
        end
    endtask

    // One full run: start is sampled at edge E0; edges are counted from E0.
    task automatic run(input int k, input logic [1023:0] n, input bit disturb);
        @(posedge clk); #1;
        drive(k, 1'b1, n);
        @(posedge clk); #1;
        drive(k, 1'b0, n);
        cap_beats   = 0;
        cap_done_e  = -1;
        cap_seq_ok  = 1'b1;
        cap_busy_ok = 1'b1;
        for (int i = 0; i < 32; i++) cap_tbl[i] = '0;
        sample(k);
        if (!smp_busy) cap_busy_ok = 1'b0;
        for (int e = 1; e <= 1200; e++) begin
            if (disturb && e == 3) drive(k, 1'b1, ~n);
            if (disturb && e == 4) drive(k, 1'b0, ~n);
            if (disturb && e == 880) drive(k, 1'b1, ~n);
            if (disturb && e == 881) drive(k, 1'b0, ~n);
            @(posedge clk); #1;
            sample(k);
            if (smp_we) begin
                if (int'(smp_addr) != cap_beats) cap_seq_ok = 1'b0;
                if (cap_beats < 32) cap_tbl[cap_beats] = smp_data;
                cap_beats++;
            end
            if (smp_done) begin
                cap_done_e    = e;
                cap_done_addr = smp_addr;
                cap_done_data = smp_data;
                cap_done_we   = smp_we;
                if (smp_busy) cap_busy_ok = 1'b0;
                break;
            end else if (!smp_busy) begin
                cap_busy_ok = 1'b0;
            end
        end
    endtask

    function automatic logic [1023:0] model_big(input logic [1023:0] n, input int i);
        logic [1023:0] p;
        logic [1023:0] b;
        logic [1029:0] t;
        logic [1029:0] r;
        p = 1024'd1 << 850;
        b = p % n;
        t = 1030'(i) * {6'd0, b};
        r = t % {6'd0, n};
        return r[1023:0];
    endfunction

    typedef struct {
        int          k;
        logic [15:0] n;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [15:0] e31;
        int          lat;
    } vec_t;

    vec_t vt [6];
    int   shift_of [3];

    initial begin
        logic [1023:0] na;
        logic [1023:0] nb;
        longint unsigned base16;
        longint unsigned m;
        int viol;
        bit found;

        clk     = 1'b0;
        reset   = 1'b1;
        a_start = '0;
        a_mod   = '0;
        d_start = 1'b0;
        d_mod   = '0;

        shift_of[0] = 20;
        shift_of[1] = 1;
        shift_of[2] = 16;
        vt[0] = '{0, 16'hFFF1, 16'd240,   16'd480,   16'd7440,  53};
        vt[1] = '{1, 16'h0003, 16'd2,     16'd1,     16'd2,     34};
        vt[2] = '{2, 16'hFFFF, 16'd1,     16'd2,     16'd31,    49};
        vt[3] = '{2, 16'h8001, 16'd32767, 16'd32765, 16'd32707, 49};
        vt[4] = '{0, 16'h0003, 16'd1,     16'd2,     16'd1,     53};
        vt[5] = '{1, 16'hFFF1, 16'd2,     16'd4,     16'd62,    34};

        // reset state
        #12;
        for (int k = 0; k < 4; k += 3) begin
            sample(k);
            chk($sformatf("rst_we k%0d", k),   1024'(smp_we),   1024'(0));
            chk($sformatf("rst_busy k%0d", k), 1024'(smp_busy), 1024'(0));
            chk($sformatf("rst_done k%0d", k), 1024'(smp_done), 1024'(0));
            chk($sformatf("rst_addr k%0d", k), 1024'(smp_addr), 1024'(0));
            chk($sformatf("rst_data k%0d", k), smp_data,        1024'(0));
        end
        @(posedge clk); #1;
        reset = 1'b0;

        // table-driven 16-bit runs
        for (int v = 0; v < 6; v++) begin
            run(vt[v].k, {1008'd0, vt[v].n}, 1'b0);
            chk($sformatf("v%0d latency", v), 1024'(cap_done_e), 1024'(vt[v].lat));
            chk($sformatf("v%0d beats", v),   1024'(cap_beats),  1024'(32));
            chk($sformatf("v%0d addr_seq", v), 1024'(cap_seq_ok), 1024'(1));
            chk($sformatf("v%0d busy_win", v), 1024'(cap_busy_ok), 1024'(1));
            chk($sformatf("v%0d done_we", v), 1024'(cap_done_we), 1024'(0));
            chk($sformatf("v%0d hold_addr", v), 1024'(cap_done_addr), 1024'(31));
            chk($sformatf("v%0d hold_data", v), cap_done_data, 1024'(vt[v].e31));
            chk($sformatf("v%0d e0", v),  cap_tbl[0],  1024'(0));
            chk($sformatf("v%0d e1", v),  cap_tbl[1],  1024'(vt[v].e1));
            chk($sformatf("v%0d e2", v),  cap_tbl[2],  1024'(vt[v].e2));
            chk($sformatf("v%0d e31", v), cap_tbl[31], 1024'(vt[v].e31));
            base16 = (64'd1 << shift_of[vt[v].k]) % longint'(vt[v].n);
            for (int i = 0; i < 32; i++) begin
                m = (base16 * longint'(i)) % longint'(vt[v].n);
                chk($sformatf("v%0d entry%0d", v, i), cap_tbl[i], 1024'(m));
            end
        end

        // start held only in the DONE cycle must be dropped
        run(0, 1024'h00FF_F1, 1'b0);
        drive(0, 1'b1, 1024'h00FF_F1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1024'h00FF_F1);
        sample(0);
        chk("done_start busy1", 1024'(smp_busy), 1024'(0));
        @(posedge clk); #1;
        sample(0);
        chk("done_start busy2", 1024'(smp_busy), 1024'(0));

        // reset during write beat 10
        @(posedge clk); #1;
        drive(0, 1'b1, 1024'h00FF_F1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1024'h00FF_F1);
        found = 1'b0;
        for (int e = 0; e < 100; e++) begin
            @(posedge clk); #1;
            sample(0);
            if (smp_we && smp_addr == 5'd10) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach beat10", 1024'(found), 1024'(1));
        #2 reset = 1'b1;
        #1 sample(0);
        chk("abort we",   1024'(smp_we),   1024'(0));
        chk("abort busy", 1024'(smp_busy), 1024'(0));
        chk("abort done", 1024'(smp_done), 1024'(0));
        chk("abort addr", 1024'(smp_addr), 1024'(0));
        chk("abort data", smp_data,        1024'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        viol = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            sample(0);
            if (smp_we || smp_busy || smp_done) viol++;
        end
        chk("post_reset quiet", 1024'(viol), 1024'(0));
        run(0, 1024'h00FF_F1, 1'b0);
        chk("rerun beats",   1024'(cap_beats),  1024'(32));
        chk("rerun seq",     1024'(cap_seq_ok), 1024'(1));
        chk("rerun latency", 1024'(cap_done_e), 1024'(53));
        chk("rerun e10",     cap_tbl[10],       1024'(2400));
        chk("rerun e31",     cap_tbl[31],       1024'(7440));

        // default size: random odd N with MSB set, disturbed while busy
        for (int w = 0; w < 32; w++) na[w*32 +: 32] = $urandom;
        na[1023] = 1'b1;
        na[0]    = 1'b1;
        // second modulus of ~800 bits so the doublings must reduce
        nb = '0;
        for (int w = 0; w < 25; w++) nb[w*32 +: 32] = $urandom;
        nb[799] = 1'b1;
        nb[0]   = 1'b1;

        run(3, na, 1'b1);
        chk("big_a latency", 1024'(cap_done_e),  1024'(883));
        chk("big_a beats",   1024'(cap_beats),   1024'(32));
        chk("big_a seq",     1024'(cap_seq_ok),  1024'(1));
        chk("big_a busy",    1024'(cap_busy_ok), 1024'(1));
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("big_a entry%0d", i), cap_tbl[i], model_big(na, i));
        end

        // back-to-back: start lands the cycle after returning to IDLE
        run(3, nb, 1'b0);
        chk("big_b latency", 1024'(cap_done_e), 1024'(883));
        chk("big_b beats",   1024'(cap_beats),  1024'(32));
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("big_b entry%0d", i), cap_tbl[i], model_big(nb, i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
